// File: rtl/uart_pkg.sv
// Shared UART definitions: assembler FSM states and the default bit and
// timeout periods, so receiver, transmitter and assembler agree.
package uart_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } asm_state_t;

    // 50 MHz clock, 19200 baud
    localparam int BAUD_CYC    = 2604;
    // ten byte times
    localparam int TIMEOUT_CYC = 260400;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle timer. Counts enabled cycles and flags expiry.
// Ports: clk, rst_n (async low), clr (zero count), en (count), expired.
module uart_byte_timer #(
    parameter int TIMEOUT_CYC = uart_pkg::TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    assign expired = en && (cnt == LAST);

    // Saturates at LAST so a missed clear can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs NUM_BYTES UART bytes (MSB first) into one command word.
// Ports: clk, rst_n, rx_data/rx_rdy/rx_rdy_clr (byte in), cmd/cmd_rdy/
// clr_cmd_rdy (command out), frame_err (partial frame dropped on timeout).
module uart_cmd_assembler #(
    parameter int NUM_BYTES   = 3,
    parameter int TIMEOUT_CYC = uart_pkg::TIMEOUT_CYC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   rx_rdy_clr,
    input  logic                   clr_cmd_rdy,
    output logic [8*NUM_BYTES-1:0] cmd,
    output logic                   cmd_rdy,
    output logic                   frame_err
);

    import uart_pkg::*;

    localparam int CW = $clog2(NUM_BYTES + 1);
    localparam int W  = 8 * NUM_BYTES;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NUM_BYTES - 1);

    asm_state_t    state;
    logic [CW-1:0] byte_cnt;
    logic          accept;
    logic          expired;
    logic          tmr_en;
    logic          tmr_clr;

    // rx_rdy stays high for the cycle rx_rdy_clr is up; masking avoids
    // capturing the same byte twice.
    assign accept  = (state == COLLECT) && rx_rdy && !rx_rdy_clr;
    assign tmr_en  = (state == COLLECT) && (byte_cnt != '0) && !accept;
    assign tmr_clr = accept || expired;

    uart_byte_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            byte_cnt   <= '0;
            cmd        <= '0;
            cmd_rdy    <= 1'b0;
            rx_rdy_clr <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_rdy_clr <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        rx_rdy_clr <= 1'b1;
                        cmd        <= {cmd[W-9:0], rx_data};
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            cmd_rdy  <= 1'b1;
                            state    <= HOLD;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (expired) begin
                        byte_cnt  <= '0;
                        frame_err <= 1'b1;
                    end
                end
                HOLD: begin
                    // Pending bytes wait upstream until the consumer clears.
                    if (clr_cmd_rdy) begin
                        cmd_rdy <= 1'b0;
                        state   <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler (3 bytes, 100-cycle timeout).
// Models the receiver's rx_rdy level cleared by rx_rdy_clr.
module tb_uart_cmd_assembler;

    localparam int NB = 3;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_rdy = 1'b0;
    logic            clr_cmd_rdy = 1'b0;
    logic            rx_rdy_clr;
    logic [8*NB-1:0] cmd;
    logic            cmd_rdy;
    logic            frame_err;

    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ack_cnt = 0;

    uart_cmd_assembler #(
        .NUM_BYTES  (NB),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .rx_rdy_clr (rx_rdy_clr),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (rx_rdy_clr) ack_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic present(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
    endtask

    // Waits for the ack pulse; lat = edges from present to capture.
    task automatic wait_ack(output int lat, output int cap);
        lat = 0;
        cap = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk);
            #1;
            if (rx_rdy_clr) begin
                lat = i;
                cap = cyc;
                break;
            end
        end
        ncmp++;
        if (lat == 0) begin
            nerr++;
            $display("FAIL ack_wait: no rx_rdy_clr within 1000 cycles");
        end
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b,
                             output int lat, output int cap);
        present(b);
        wait_ack(lat, cap);
    endtask

    task automatic clear_cmd();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int lat, cap;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        ncmp++;
        if ({cmd, cmd_rdy, rx_rdy_clr, frame_err} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs got cmd=%h rdy=%b clr=%b fe=%b want 0",
                     cmd, cmd_rdy, rx_rdy_clr, frame_err);
        end
        rst_n = 1'b1;
        send_byte(8'h01, lat, cap);
        send_byte(8'h02, lat, cap);
        ncmp++;
        if (cmd !== 24'h000102) begin
            nerr++;
            $display("FAIL reset_partial got %h want 000102", cmd);
        end
        #2 rst_n = 1'b0;
        #1;
        ncmp++;
        if ({cmd, cmd_rdy, rx_rdy_clr, frame_err} !== '0) begin
            nerr++;
            $display("FAIL reset_async got cmd=%h rdy=%b want 0", cmd, cmd_rdy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h11, lat, cap);
        send_byte(8'h22, lat, cap);
        send_byte(8'h33, lat, cap);
        ncmp++;
        if (cmd_rdy !== 1'b1 || cmd !== 24'h112233) begin
            nerr++;
            $display("FAIL reset_after got rdy=%b cmd=%h want 1 112233",
                     cmd_rdy, cmd);
        end
        clear_cmd();
    endtask

    task automatic test_basic();
        int lat, cap, fe0, ack0, bad_lat;
        logic [7:0] bytes [3];
        bytes[0] = 8'hA5;
        bytes[1] = 8'h5A;
        bytes[2] = 8'h3C;
        do_reset();
        fe0 = fe_cnt;
        ack0 = ack_cnt;
        bad_lat = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                ncmp++;
                if (cmd_rdy !== 1'b0) begin
                    nerr++;
                    $display("FAIL basic_early_rdy got %b want 0", cmd_rdy);
                end
            end
            send_byte(bytes[i], lat, cap);
            if (lat != 1) bad_lat++;
            if (i == 2) begin
                ncmp++;
                if (cmd_rdy !== 1'b1 || cmd !== 24'hA55A3C) begin
                    nerr++;
                    $display("FAIL basic_cmd got rdy=%b cmd=%h want 1 a55a3c",
                             cmd_rdy, cmd);
                end
            end else begin
                repeat (40) @(posedge clk);
            end
        end
        ncmp++;
        if (bad_lat != 0) begin
            nerr++;
            $display("FAIL basic_latency got %0d late captures want 0", bad_lat);
        end
        ncmp++;
        if (ack_cnt - ack0 != 3) begin
            nerr++;
            $display("FAIL basic_acks got %0d want 3", ack_cnt - ack0);
        end
        ncmp++;
        if (fe_cnt != fe0) begin
            nerr++;
            $display("FAIL basic_frame_err got %0d want 0", fe_cnt - fe0);
        end
    endtask

    task automatic test_backpressure();
        int bad, ack0;
        ack0 = ack_cnt;
        bad = 0;
        present(8'h77);
        repeat (500) begin
            @(posedge clk);
            #1;
            if (rx_rdy_clr || !cmd_rdy || cmd !== 24'hA55A3C) bad++;
        end
        ncmp++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        end
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        ncmp++;
        if (cmd_rdy !== 1'b0 || rx_rdy_clr !== 1'b0) begin
            nerr++;
            $display("FAIL bp_clear got rdy=%b clr=%b want 0 0",
                     cmd_rdy, rx_rdy_clr);
        end
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        @(posedge clk);
        #1;
        ncmp++;
        if (rx_rdy_clr !== 1'b1 || cmd !== 24'h5A3C77) begin
            nerr++;
            $display("FAIL bp_capture got clr=%b cmd=%h want 1 5a3c77",
                     rx_rdy_clr, cmd);
        end
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        ncmp++;
        if (ack_cnt - ack0 != 1) begin
            nerr++;
            $display("FAIL bp_acks got %0d want 1", ack_cnt - ack0);
        end
    endtask

    task automatic test_timeout();
        int lat, cap, fe0, seen;
        do_reset();
        fe0 = fe_cnt;
        send_byte(8'h01, lat, cap);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                seen = cyc - cap;
                break;
            end
        end
        ncmp++;
        if (seen != TO) begin
            nerr++;
            $display("FAIL to_timing got %0d cycles want %0d", seen, TO);
        end
        @(posedge clk);
        #1;
        ncmp++;
        if (frame_err !== 1'b0 || cmd_rdy !== 1'b0) begin
            nerr++;
            $display("FAIL to_pulse got fe=%b rdy=%b want 0 0",
                     frame_err, cmd_rdy);
        end
        send_byte(8'hDE, lat, cap);
        send_byte(8'hAD, lat, cap);
        send_byte(8'hBE, lat, cap);
        ncmp++;
        if (cmd_rdy !== 1'b1 || cmd !== 24'hDEADBE) begin
            nerr++;
            $display("FAIL to_recover got rdy=%b cmd=%h want 1 deadbe",
                     cmd_rdy, cmd);
        end
        ncmp++;
        if (fe_cnt - fe0 != 1) begin
            nerr++;
            $display("FAIL to_count got %0d want 1", fe_cnt - fe0);
        end
        clear_cmd();
    endtask

    task automatic test_race();
        int lat, cap, fe0;
        do_reset();
        fe0 = fe_cnt;
        send_byte(8'h10, lat, cap);
        // The expiry cycle follows edge cap+TO-1 counted from capture.
        repeat (cap + TO - 1 - cyc) @(posedge clk);
        present(8'h20);
        wait_ack(lat, cap);
        ncmp++;
        if (lat != 1) begin
            nerr++;
            $display("FAIL race_latency got %0d want 1", lat);
        end
        send_byte(8'h30, lat, cap);
        ncmp++;
        if (cmd_rdy !== 1'b1 || cmd !== 24'h102030) begin
            nerr++;
            $display("FAIL race_cmd got rdy=%b cmd=%h want 1 102030",
                     cmd_rdy, cmd);
        end
        ncmp++;
        if (fe_cnt != fe0) begin
            nerr++;
            $display("FAIL race_frame_err got %0d want 0", fe_cnt - fe0);
        end
        clear_cmd();
    endtask

    task automatic test_stray_clear();
        int lat, cap;
        do_reset();
        send_byte(8'h44, lat, cap);
        clear_cmd();
        ncmp++;
        if (cmd_rdy !== 1'b0 || cmd !== 24'h000044) begin
            nerr++;
            $display("FAIL stray_state got rdy=%b cmd=%h want 0 000044",
                     cmd_rdy, cmd);
        end
        send_byte(8'h55, lat, cap);
        send_byte(8'h66, lat, cap);
        ncmp++;
        if (cmd_rdy !== 1'b1 || cmd !== 24'h445566) begin
            nerr++;
            $display("FAIL stray_cmd got rdy=%b cmd=%h want 1 445566",
                     cmd_rdy, cmd);
        end
        clear_cmd();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_race();
        test_stray_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Sits directly downstream of the UART receiver. Consumes its rx_data/rx_rdy byte stream and acknowledges each byte with rx_rdy_clr.
- Packs NUM_BYTES consecutive bytes, MSB first, into one command word and presents it with a cmd_rdy/clr_cmd_rdy handshake to the command-processing logic.
- An inter-byte timeout discards partial frames so a lost byte cannot misalign later commands.

Parameters:
- NUM_BYTES, 3, bytes per command; legal range 2..4; cmd width = 8*NUM_BYTES.
- TIMEOUT_CYC, 260400, idle clk cycles allowed between bytes of one frame (10 byte times at 19200 baud, 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from UART receiver; valid while rx_rdy=1
- rx_rdy  in  1  level; byte available; stays high until cleared via rx_rdy_clr
- rx_rdy_clr  out  1  one-cycle pulse acknowledging the captured byte
- clr_cmd_rdy  in  1  consumer has taken cmd; clears cmd_rdy
- cmd  out  8*NUM_BYTES  assembled command; first byte received in the MSBs
- cmd_rdy  out  1  level; cmd valid and stable
- frame_err  out  1  one-cycle pulse when a partial frame is discarded on timeout

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. All outputs, state, counters and the shift register are cleared to 0 by rst_n at any time, including mid-frame. The state returns to COLLECT with byte_cnt=0.
- Reset values: cmd=0, cmd_rdy=0, rx_rdy_clr=0, frame_err=0.
- States: COLLECT and HOLD.
- Byte acceptance in COLLECT:
  - accept = rx_rdy && !rx_rdy_clr.
  - On an accepting edge: cmd <= {cmd[8*NUM_BYTES-9:0], rx_data}; byte_cnt += 1; timeout counter cleared.
  - rx_rdy_clr is registered, so it is high for exactly the cycle after capture.
  - The !rx_rdy_clr term blocks double-capture while the upstream rx_rdy is still falling.
- Frame completion:
  - The edge that captures byte NUM_BYTES sets cmd_rdy=1, resets byte_cnt to 0 and moves to HOLD.
  - cmd is visible one cycle after the last rx_rdy is sampled.
- HOLD:
  - cmd and cmd_rdy are held stable.
  - rx_rdy is not acknowledged; no rx_rdy_clr, no capture. This is backpressure: upstream keeps its byte pending.
  - Timeout counter is idle.
  - clr_cmd_rdy=1 gives cmd_rdy=0 on the next edge and a return to COLLECT. cmd keeps its value; it is not cleared.
  - A byte pending during the clear edge is captured on the following edge (no loss).
- clr_cmd_rdy in COLLECT is ignored.
- Timeout:
  - In COLLECT with byte_cnt!=0, the timeout counter increments each cycle without accept.
  - When it reaches TIMEOUT_CYC-1: byte_cnt <= 0, counter <= 0, frame_err pulses high for 1 cycle. cmd contents are don't-care but are not presented, since cmd_rdy stays 0.
  - The counter does not run when byte_cnt==0.
  - Timeout expiry and accept in the same cycle: accept wins; byte captured, counter cleared, no frame_err.
- Widths: timeout counter is $clog2(TIMEOUT_CYC) bits and saturates at the expiry compare (no wrap). byte_cnt is $clog2(NUM_BYTES+1) bits.
- Throughput: limited only by upstream. One byte per 2 clk minimum (capture, then clr cycle).

Decomposition:
- Shared package uart_pkg:
  - asm_state_t enum {COLLECT, HOLD}
  - default constants BAUD_CYC=2604 and TIMEOUT_CYC=260400, so receiver, transmitter and assembler agree.
- Sub-module: inter-byte timer uart_byte_timer, with ports clk, rst_n, clr, en and expired.
- Remaining datapath and FSM stay flat in uart_cmd_assembler.

Test Plan (NUM_BYTES=3, TIMEOUT_CYC=100 in bench; bench models the receiver's rx_rdy/rx_rdy_clr behaviour):
- Reset mid-frame: after 2 bytes, pulse rst_n low asynchronously between edges -> all outputs 0 immediately. Next bytes 0x11,0x22,0x33 -> cmd=0x112233.
- Basic frame: bytes 0xA5,0x5A,0x3C, 40 cycles apart -> each byte gives one rx_rdy_clr pulse on the cycle after capture. cmd_rdy=1 with cmd=0xA55A3C on the edge after the third byte is sampled; frame_err never asserts.
- Backpressure: hold clr_cmd_rdy=0 for 500 cycles after cmd_rdy while a 4th byte 0x77 is pending -> no rx_rdy_clr, cmd stays 0xA55A3C. Pulse clr_cmd_rdy -> cmd_rdy=0 next edge; 0x77 captured the edge after; rx_rdy_clr pulses once.
- Timeout: send 0x01, wait 100 cycles -> frame_err single pulse, no cmd_rdy. Then 0xDE,0xAD,0xBE -> cmd=0xDEADBE.
- Race at expiry: after one byte, present the next byte exactly on the expiry cycle -> no frame_err; frame completes normally.
- Stray clear: clr_cmd_rdy pulsed in COLLECT after one byte -> no effect; frame completes with correct cmd.
